proc_cmd_port: RTL and testbench
================================

PROC_CMD_PORT -- requirements
Module: proc_cmd_port

Interface
REQ-001 Parameter DATA_W, default 32: width of each instruction beat and of each operand/info register.
REQ-002 Parameter CMD_ID_W, default 8: width of the command id; the id is info-word bits [CMD_ID_W-1:0]; CMD_ID_W SHALL be <= DATA_W.
REQ-003 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_en  in  1  issuer beat valid.
REQ-006 i_instr  in  DATA_W  issuer beat payload.
REQ-007 o_beat_ack  out  1  one-cycle pulse acknowledging a captured beat; wired to the issuer's ack input.
REQ-008 o_busy  out  1  port occupied; wired to the issuer's busy bit for this processor.
REQ-009 o_finish  out  1  command complete, held until acknowledged.
REQ-010 o_finish_id  out  CMD_ID_W  id of the completed command, valid while o_finish=1.
REQ-011 i_finish_ack  in  1  issuer's one-hot ack bit for this processor.
REQ-012 o_start  out  1  one-cycle pulse to the core: operands valid.
REQ-013 o_op_a, o_op_b, o_info  out  DATA_W each  captured beats 0, 1, 2; stable from o_start until return to IDLE.
REQ-014 i_done  in  1  core completion pulse.
REQ-015 o_proto_err  out  1  sticky protocol-violation flag.

Function
REQ-016 States SHALL be IDLE, LD2, INFO, START, EXEC, FINISH; all outputs registered.
REQ-017 Beat capture: in IDLE, LD2 or INFO, i_en=1 with o_beat_ack=0 SHALL capture i_instr into op_a, op_b or info respectively and assert o_beat_ack in the next cycle only.
REQ-018 While o_beat_ack=1, i_en SHALL be ignored; an issuer holding i_en for two cycles SHALL cause exactly one capture.
REQ-019 Transitions: IDLE->LD2 on beat 0; LD2->INFO on beat 1; INFO->START on beat 2; START->EXEC unconditionally after one cycle; EXEC->FINISH on i_done=1; FINISH->IDLE on i_finish_ack=1.
REQ-020 o_busy SHALL be 1 in every state except IDLE; it rises the cycle after beat 0 is captured (coincident with o_beat_ack) and falls the cycle after i_finish_ack is sampled.
REQ-021 o_start SHALL be 1 exactly while in START (the cycle after beat 2 is captured, coincident with its o_beat_ack).
REQ-022 Entering FINISH SHALL set o_finish=1 and o_finish_id=info[CMD_ID_W-1:0]; both SHALL hold until the cycle after i_finish_ack, then o_finish=0 and o_finish_id=0.
REQ-023 i_done outside EXEC (including in START) SHALL be ignored.
REQ-024 i_finish_ack outside FINISH SHALL be ignored.
REQ-025 i_en=1 in START, EXEC or FINISH SHALL produce no capture and no o_beat_ack, and SHALL set o_proto_err=1.
REQ-026 i_en=1 together with i_finish_ack=1 in FINISH SHALL set o_proto_err, return to IDLE, and capture no beat; the next beat is accepted no earlier than the following cycle.
REQ-027 Back-to-back commands: beat 0 of the next command SHALL be accepted in the first cycle in IDLE.
REQ-028 Latency: beat 2 to o_start is 1 cycle; i_done to o_finish is 1 cycle; i_finish_ack to o_busy=0 is 1 cycle.

Reset
REQ-029 i_rst=1 at a clock edge SHALL force state IDLE, zero all registers and outputs (o_beat_ack, o_busy, o_finish, o_finish_id, o_start, o_op_a, o_op_b, o_info, o_proto_err), and discard any partially loaded command, regardless of state.
REQ-030 i_en, i_done and i_finish_ack SHALL be ignored in any cycle where i_rst=1.

Verification
REQ-031 Beats 0x11, 0x22, 0x0000_0A05 with i_en pulsed one cycle each, gaps of 1 cycle -> three o_beat_ack pulses; o_busy=1 from the first ack; o_start one cycle with op_a=0x11, op_b=0x22, info=0xA05.
REQ-032 After REQ-031, i_done at EXEC cycle 4 -> o_finish=1 and o_finish_id=0x05 next cycle; hold i_finish_ack low 10 cycles -> outputs stable; i_finish_ack one cycle -> o_finish=0, o_busy=0 next cycle.
REQ-033 i_en held high continuously with payload 0x11 for 6 cycles from IDLE -> exactly three captures (acks on cycles 1, 3, 5), then o_proto_err=1 on cycle 6, state START/EXEC unaffected.
REQ-034 i_done asserted in LD2 and in START, i_finish_ack asserted in EXEC -> no state change beyond REQ-019; o_finish stays 0.
REQ-035 i_rst asserted one cycle while in INFO with op_a=0x11 loaded -> next cycle all outputs 0, state IDLE; fresh beat 0x33 -> op_a=0x33, normal sequence.
REQ-036 Two commands back-to-back (ids 0x05, 0x06), beat 0 of the second presented in the cycle o_busy falls -> accepted immediately; second o_finish_id=0x06.

Source files
------------

// File: rtl/proc_cmd_port.sv
// proc_cmd_port: processor-side command port.
// Takes a three-beat command from the issuer (op_a, op_b, info) and pulses
// o_start to the core. It then waits for i_done and reports completion with
// o_finish/o_finish_id until the issuer acknowledges.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_en, i_instr             issuer beat valid / payload
//   o_beat_ack                one-cycle ack for each captured beat
//   o_busy                    high in every state except IDLE
//   o_finish, o_finish_id     completion flag and command id, held until acked
//   i_finish_ack              issuer acknowledge of completion
//   o_start                   one-cycle pulse: operands valid to the core
//   o_op_a, o_op_b, o_info    captured beats 0, 1, 2
//   i_done                    core completion pulse
//   o_proto_err               sticky: beat offered while not accepting
module proc_cmd_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CMD_ID_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [DATA_W-1:0]   i_instr,
  output logic                o_beat_ack,
  output logic                o_busy,
  output logic                o_finish,
  output logic [CMD_ID_W-1:0] o_finish_id,
  input  logic                i_finish_ack,
  output logic                o_start,
  output logic [DATA_W-1:0]   o_op_a,
  output logic [DATA_W-1:0]   o_op_b,
  output logic [DATA_W-1:0]   o_info,
  input  logic                i_done,
  output logic                o_proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD2,
    S_INFO,
    S_START,
    S_EXEC,
    S_FINISH
  } state_e;

  state_e              state_q;
  logic                beat_ack_q;
  logic                busy_q;
  logic                finish_q;
  logic [CMD_ID_W-1:0] finish_id_q;
  logic                start_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [DATA_W-1:0]   info_q;
  logic                proto_err_q;

  logic loading;
  logic capture;

  // A beat is taken only while loading and never in the ack cycle, so an
  // issuer holding i_en for two cycles yields a single capture.
  always_comb begin
    loading = (state_q == S_IDLE) || (state_q == S_LD2) || (state_q == S_INFO);
    capture = i_en && !beat_ack_q && loading;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      beat_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      finish_id_q <= '0;
      start_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      info_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      beat_ack_q <= capture;
      start_q    <= 1'b0;

      // Any beat offered outside the loading states is a protocol error,
      // including the FINISH cycle where the ack also arrives.
      if (i_en && !loading) begin
        proto_err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (capture) begin
            op_a_q  <= i_instr;
            busy_q  <= 1'b1;
            state_q <= S_LD2;
          end
        end
        S_LD2: begin
          if (capture) begin
            op_b_q  <= i_instr;
            state_q <= S_INFO;
          end
        end
        S_INFO: begin
          if (capture) begin
            info_q  <= i_instr;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (i_done) begin
            finish_q    <= 1'b1;
            finish_id_q <= info_q[CMD_ID_W-1:0];
            state_q     <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (i_finish_ack) begin
            finish_q    <= 1'b0;
            finish_id_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_beat_ack  = beat_ack_q;
  assign o_busy      = busy_q;
  assign o_finish    = finish_q;
  assign o_finish_id = finish_id_q;
  assign o_start     = start_q;
  assign o_op_a      = op_a_q;
  assign o_op_b      = op_b_q;
  assign o_info      = info_q;
  assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_proc_cmd_port.sv
// tb_proc_cmd_port: directed bench for proc_cmd_port with a beat-counting
// reference model compared every cycle, plus literal expectations.
module tb_proc_cmd_port;
  localparam int DW = 32;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst, en, done, fack;
  logic [DW-1:0] instr;
  logic          ack, busy, fin, start, perr;
  logic [IW-1:0] fid;
  logic [DW-1:0] op_a, op_b, info;

  proc_cmd_port #(.DATA_W(DW), .CMD_ID_W(IW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_instr(instr),
    .o_beat_ack(ack), .o_busy(busy), .o_finish(fin), .o_finish_id(fid),
    .i_finish_ack(fack), .o_start(start), .o_op_a(op_a), .o_op_b(op_b),
    .o_info(info), .i_done(done), .o_proto_err(perr)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts beats of the current command. Three beats means
  // operands delivered; the cycle right after is the start pulse, after which
  // i_done is honoured until completion is reported and acknowledged.
  int            nb, onb;
  bit            m_start, m_fin, m_ack, m_err, m_valid;
  bit            ostart, ofin, oack;
  logic [DW-1:0] m_slot [3];
  logic [IW-1:0] m_fid;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      nb = 0; m_start = 0; m_fin = 0; m_ack = 0; m_err = 0; m_fid = '0;
      for (int i = 0; i < 3; i++) m_slot[i] = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      onb = nb; ostart = m_start; ofin = m_fin; oack = m_ack;
      m_ack = 0; m_start = 0;
      if (en) begin
        if (onb < 3) begin
          if (!oack) begin
            m_slot[onb] = instr;
            nb = onb + 1;
            m_ack = 1;
            m_start = (nb == 3);
          end
        end else begin
          m_err = 1;
        end
      end
      if (onb == 3 && !ostart && !ofin && done) begin
        m_fin = 1;
        m_fid = m_slot[2][IW-1:0];
      end
      if (ofin && fack) begin
        m_fin = 0; m_fid = '0; nb = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_ack",   DW'(ack),   DW'(m_ack));
      chk("m_busy",  DW'(busy),  DW'(nb > 0));
      chk("m_start", DW'(start), DW'(m_start));
      chk("m_fin",   DW'(fin),   DW'(m_fin));
      chk("m_fid",   DW'(fid),   DW'(m_fid));
      chk("m_op_a",  op_a,       m_slot[0]);
      chk("m_op_b",  op_b,       m_slot[1]);
      chk("m_info",  info,       m_slot[2]);
      chk("m_perr",  DW'(perr),  DW'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    en = 1'b1; instr = d; step(); en = 1'b0;
  endtask

  // Three beats with one-cycle gaps; returns in EXEC cycle 1.
  task automatic load_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] inf);
    beat(a); step(); beat(b); step(); beat(inf);
    chk("ld_start", DW'(start), 1);
    step();
  endtask

  task automatic complete(input logic [IW-1:0] id);
    done = 1'b1; step(); done = 1'b0;
    chk("cp_fin", DW'(fin), 1);
    chk("cp_fid", DW'(fid), DW'(id));
    fack = 1'b1; step(); fack = 1'b0;
    chk("cp_busy", DW'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; done = 1'b0; fack = 1'b0; instr = '0;
    step(); step();
    chk("rst_busy", DW'(busy), 0);
    chk("rst_fin",  DW'(fin),  0);
    chk("rst_opa",  op_a,      0);
    chk("rst_perr", DW'(perr), 0);
    rst = 1'b0;

    // Basic command: 0x11, 0x22, 0xA05
    beat(32'h11);
    chk("b0_ack", DW'(ack), 1); chk("b0_busy", DW'(busy), 1);
    step();
    chk("b0_ack_off", DW'(ack), 0);
    beat(32'h22);
    chk("b1_ack", DW'(ack), 1);
    step();
    beat(32'h0000_0A05);
    chk("b2_start", DW'(start), 1); chk("b2_ack", DW'(ack), 1);
    chk("b2_opa", op_a, 32'h11); chk("b2_opb", op_b, 32'h22); chk("b2_info", info, 32'hA05);
    step();
    chk("exec_start_off", DW'(start), 0);
    step(); step(); step();
    done = 1'b1; step(); done = 1'b0;
    chk("fin_set", DW'(fin), 1); chk("fin_id", DW'(fid), 32'h05);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("fin_hold", DW'(fin), 1); chk("fid_hold", DW'(fid), 32'h05);
    end
    fack = 1'b1; step(); fack = 1'b0;
    chk("ack_fin", DW'(fin), 0); chk("ack_busy", DW'(busy), 0); chk("ack_fid", DW'(fid), 0);

    // i_en held for 6 cycles
    en = 1'b1; instr = 32'h11;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("hold_ack", DW'(ack), DW'((i % 2) == 1 && i <= 5));
      if (i == 5) chk("hold_noerr", DW'(perr), 0);
    end
    en = 1'b0;
    chk("hold_err", DW'(perr), 1);
    chk("hold_busy", DW'(busy), 1);
    complete(8'h11);
    rst = 1'b1; step(); rst = 1'b0;
    chk("err_clr", DW'(perr), 0);

    // Stray i_done in LD2/START, stray ack in EXEC
    beat(32'h44);
    done = 1'b1; step(); done = 1'b0;
    chk("ld2_done", DW'(fin), 0);
    beat(32'h55); step();
    beat(32'h107);
    done = 1'b1; step(); done = 1'b0;
    chk("start_done", DW'(fin), 0);
    fack = 1'b1; step(); fack = 1'b0;
    chk("exec_fack_busy", DW'(busy), 1); chk("exec_fack_fin", DW'(fin), 0);
    complete(8'h07);

    // Reset while in INFO
    beat(32'h11); step(); beat(32'h22); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_info_opa", op_a, 0); chk("rst_info_opb", op_b, 0); chk("rst_info_busy", DW'(busy), 0);
    beat(32'h33);
    chk("fresh_opa", op_a, 32'h33); chk("fresh_ack", DW'(ack), 1);
    step(); beat(32'h44); step(); beat(32'h1FF);
    chk("fresh_start", DW'(start), 1);
    step();
    complete(8'hFF);

    // Back-to-back commands, next beat 0 in the cycle busy falls
    load_cmd(32'h1, 32'h2, 32'h205);
    done = 1'b1; step(); done = 1'b0;
    chk("bb1_fid", DW'(fid), 32'h05);
    fack = 1'b1; step(); fack = 1'b0;
    chk("bb_busy_low", DW'(busy), 0);
    beat(32'h66);
    chk("bb_ack", DW'(ack), 1); chk("bb_opa", op_a, 32'h66); chk("bb_busy", DW'(busy), 1);
    step(); beat(32'h67); step(); beat(32'h306); step();
    done = 1'b1; step(); done = 1'b0;
    chk("bb2_fid", DW'(fid), 32'h06);

    // i_en together with i_finish_ack in FINISH
    en = 1'b1; fack = 1'b1; instr = 32'h99; step(); en = 1'b0; fack = 1'b0;
    chk("fe_busy", DW'(busy), 0); chk("fe_err", DW'(perr), 1);
    chk("fe_ack", DW'(ack), 0); chk("fe_opa", op_a, 32'h66);
    beat(32'h77);
    chk("fe_next_ack", DW'(ack), 1); chk("fe_next_opa", op_a, 32'h77);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
